cam_line_writer: RTL

//  Upstream stage of the 1024x16 line SRAM. Samples camera bytes (VSYNC/HREF/8-bit data,
//  one-cycle pixel strobe already in CLK domain) and packs byte pairs into 16-bit RGB565 words.

---
 rtl/cam_line_writer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cam_line_writer.sv
// Camera byte-pair packer feeding the line SRAM; writes win over pass-through reads.
// Optional CAM_BYTE_SWAP_EN puts the first camera byte in the low half of each word.
module cam_line_writer #(
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = 640
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CAM_VSYNC,
   input  logic              CAM_HREF,
   input  logic              CAM_VALID,
   input  logic [7:0]        CAM_DATA,
   input  logic              RD_REQ,
   output logic              RD_GRANT,
   output logic              CS_N,
   output logic              WR_N,
   output logic [ADDR_W-1:0] WRADDR,
   output logic [15:0]       WRDATA,
   output logic              LINE_DONE,
   output logic [ADDR_W:0]   LINE_LEN,
   output logic              ODD_ERR,
   output logic              OVF_ERR
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_HREF,
      S_BYTE_HI,
      S_BYTE_LO,
      S_LINE_END
   } state_t;

   localparam logic [ADDR_W:0] MAX_C = (ADDR_W+1)'(MAX_WORDS);

   state_t              state_q, state_d;
   logic                vsync_q, vsync_prev_q;
   logic                href_q, href_prev_q;
   logic [7:0]          hi_q, hi_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [15:0]         data_q, data_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic                done_q, done_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic                odd_q, odd_d;
   logic                ovf_q, ovf_d;

   logic                vsync_fall;
   logic                href_rise;
   logic                href_fall;
   logic                pix;
   logic [15:0]         word;

   assign vsync_fall = vsync_prev_q & ~vsync_q;
   assign href_rise  = href_q & ~href_prev_q;
   assign href_fall  = href_prev_q & ~href_q;
   assign pix        = CAM_VALID & href_q;

`ifdef CAM_BYTE_SWAP_EN
   assign word = {CAM_DATA, hi_q};
`else
   assign word = {hi_q, CAM_DATA};
`endif

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      len_d   = len_q;
      odd_d   = odd_q;
      ovf_d   = ovf_q;
      if (we_q) cnt_d = cnt_q + 1'b1;
      if (vsync_q) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (vsync_fall) state_d = S_WAIT_HREF;
            end
            S_WAIT_HREF: begin
               if (href_rise) begin
                  state_d = S_BYTE_HI;
                  cnt_d   = '0;
               end
            end
            S_BYTE_HI: begin
               if (href_fall) begin
                  state_d = S_LINE_END;
               end else if (pix) begin
                  hi_d    = CAM_DATA;
                  state_d = S_BYTE_LO;
               end
            end
            S_BYTE_LO: begin
               if (href_fall) begin
                  state_d = S_LINE_END;
                  odd_d   = 1'b1;
               end else if (pix) begin
                  state_d = S_BYTE_HI;
                  // counter saturates at MAX_WORDS; excess words are dropped
                  if (cnt_q == MAX_C) begin
                     ovf_d = 1'b1;
                  end else begin
                     we_d   = 1'b1;
                     addr_d = cnt_q[ADDR_W-1:0];
                     data_d = word;
                  end
               end
            end
            S_LINE_END: begin
               done_d  = 1'b1;
               len_d   = cnt_q;
               state_d = S_WAIT_HREF;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         vsync_q      <= 1'b0;
         vsync_prev_q <= 1'b0;
         href_q       <= 1'b0;
         href_prev_q  <= 1'b0;
         hi_q         <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         cnt_q        <= '0;
         done_q       <= 1'b0;
         len_q        <= '0;
         odd_q        <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         vsync_q      <= CAM_VSYNC;
         vsync_prev_q <= vsync_q;
         href_q       <= CAM_HREF;
         href_prev_q  <= href_q;
         hi_q         <= hi_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         cnt_q        <= cnt_d;
         done_q       <= done_d;
         len_q        <= len_d;
         odd_q        <= odd_d;
         ovf_q        <= ovf_d;
      end
   end

   assign RD_GRANT  = RD_REQ & ~we_q & ~RST;
   assign CS_N      = ~(we_q | RD_GRANT);
   assign WR_N      = ~we_q;
   assign WRADDR    = addr_q;
   assign WRDATA    = data_q;
   assign LINE_DONE = done_q;
   assign LINE_LEN  = len_q;
   assign ODD_ERR   = odd_q;
   assign OVF_ERR   = ovf_q;

endmodule
